// File: rtl/inst_queue_way1_pkg.sv
// Shared types and widths for the way-1 fetch / instruction queue / decode path.
package inst_queue_way1_pkg;

    localparam int IQ_DEPTH  = 4;
    localparam int IQ_INST_W = 32;
    localparam int IQ_ADDR_W = 32;

    typedef struct packed {
        logic [IQ_INST_W-1:0] inst;
        logic [IQ_ADDR_W-1:0] inst_addr;
    } entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/inst_queue_way1_if.sv
// Fetch-side and decode-side handshake of the way-1 instruction queue.
interface inst_queue_way1_if
    import inst_queue_way1_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int INST_W = IQ_INST_W,
    parameter int ADDR_W = IQ_ADDR_W
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic              valid_i;
    logic [INST_W-1:0] inst_i;
    logic [ADDR_W-1:0] instAddr_i;
    logic              ready_o;
    logic              jumpFlag_i;
    logic              valid_o;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] instAddr_o;
    logic              ready_i;
    logic [CNT_W-1:0]  count_o;

    // Queue side.
    modport slave (
        input  valid_i, inst_i, instAddr_i, jumpFlag_i, ready_i,
        output ready_o, valid_o, inst_o, instAddr_o, count_o
    );

    // Fetch/decode side.
    modport master (
        output valid_i, inst_i, instAddr_i, jumpFlag_i, ready_i,
        input  ready_o, valid_o, inst_o, instAddr_o, count_o
    );

endinterface

// File: rtl/inst_queue_way1_fifo_ctrl.sv
// Pointer/occupancy control for the way-1 instruction queue; a flush overrides push and pop.
module fifo_ctrl_way1 #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic             ready_in,
    input  logic             flush,
    output logic             push,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = valid_in & ~full & ~flush;
    assign pop   = ~empty & ~flush & ready_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
        count <= CNT_W'(DEPTH));
    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n)
        !(pop && empty));

endmodule

// File: rtl/inst_queue_way1.sv
// Way-1 instruction queue: circular buffer between fetch and decode, flushed on a jump.
module inst_queue_way1
    import inst_queue_way1_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int INST_W = IQ_INST_W,
    parameter int ADDR_W = IQ_ADDR_W
) (
    input logic            clk,
    input logic            reset_n,
    inst_queue_way1_if.slave q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] inst_addr;
    } slot_t;

    slot_t            mem [DEPTH];
    slot_t            head;
    logic             push;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    fifo_ctrl_way1 #(.DEPTH(DEPTH)) u_ctrl (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid_in (q.valid_i),
        .ready_in (q.ready_i),
        .flush    (q.jumpFlag_i),
        .push     (push),
        .rd_ptr   (rd_ptr),
        .wr_ptr   (wr_ptr),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Storage is deliberately left unreset; empty gating hides stale slots.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{inst: q.inst_i, inst_addr: q.instAddr_i};
        end
    end

    assign head         = mem[rd_ptr];
    assign q.inst_o     = empty ? '0 : head.inst;
    assign q.instAddr_o = empty ? '0 : head.inst_addr;
    assign q.valid_o    = ~empty & ~q.jumpFlag_i;
    assign q.ready_o    = ~full;
    assign q.count_o    = count;

endmodule

// File: tb/tb_inst_queue_way1.sv
// Bench for inst_queue_way1: directed table, corner sequences and random traffic vs a queue model.
module tb_inst_queue_way1;
    import inst_queue_way1_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    entry_t mq[$];

    inst_queue_way1_if #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32)) qif ();

    inst_queue_way1 #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (qif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] addr;
        logic        j;
        logic        r;
        logic        ev;
        logic        er;
        logic [31:0] einst;
        logic [31:0] eaddr;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model at posedge.
    task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                       input logic j, input logic r,
                       output logic ov, output logic orr, output logic [31:0] oinst,
                       output logic [31:0] oaddr, output logic [2:0] ocnt);
        bit          mv;
        bit          mr;
        logic [31:0] minst;
        logic [31:0] maddr;
        entry_t      e;
        @(negedge clk);
        qif.valid_i    = v;
        qif.inst_i     = inst;
        qif.instAddr_i = addr;
        qif.jumpFlag_i = j;
        qif.ready_i    = r;
        #1;
        mv    = (mq.size() != 0) && !j;
        mr    = (mq.size() != DEPTH);
        minst = (mq.size() != 0) ? mq[0].inst : 32'h0;
        maddr = (mq.size() != 0) ? mq[0].inst_addr : 32'h0;
        ov = qif.valid_o; orr = qif.ready_o; oinst = qif.inst_o;
        oaddr = qif.instAddr_o; ocnt = qif.count_o;
        chk("model valid_o", 64'(ov), 64'(mv));
        chk("model ready_o", 64'(orr), 64'(mr));
        chk("model inst_o", 64'(oinst), 64'(minst));
        chk("model instAddr_o", 64'(oaddr), 64'(maddr));
        chk("model count_o", 64'(ocnt), 64'(mq.size()));
        @(posedge clk);
        if (j) begin
            mq.delete();
        end else begin
            if (mv && r) void'(mq.pop_front());
            if (v && mr) begin
                e.inst = inst;
                e.inst_addr = addr;
                mq.push_back(e);
            end
        end
    endtask

    initial begin
        logic        ov, orr;
        logic [31:0] oinst, oaddr;
        logic [2:0]  ocnt;

        tbl[0]  = '{1, 32'h13,  32'h80000000, 0, 0, 0, 1, 32'h0,   32'h0,        3'd0};
        tbl[1]  = '{0, 32'h0,   32'h0,        0, 0, 1, 1, 32'h13,  32'h80000000, 3'd1};
        tbl[2]  = '{1, 32'h100, 32'h80000004, 0, 0, 1, 1, 32'h13,  32'h80000000, 3'd1};
        tbl[3]  = '{1, 32'h101, 32'h80000008, 0, 0, 1, 1, 32'h13,  32'h80000000, 3'd2};
        tbl[4]  = '{1, 32'h102, 32'h8000000C, 0, 0, 1, 1, 32'h13,  32'h80000000, 3'd3};
        tbl[5]  = '{1, 32'h103, 32'h80000010, 0, 0, 1, 0, 32'h13,  32'h80000000, 3'd4};
        tbl[6]  = '{0, 32'h0,   32'h0,        0, 1, 1, 0, 32'h13,  32'h80000000, 3'd4};
        tbl[7]  = '{0, 32'h0,   32'h0,        0, 1, 1, 1, 32'h100, 32'h80000004, 3'd3};
        tbl[8]  = '{0, 32'h0,   32'h0,        0, 1, 1, 1, 32'h101, 32'h80000008, 3'd2};
        tbl[9]  = '{0, 32'h0,   32'h0,        0, 1, 1, 1, 32'h102, 32'h8000000C, 3'd1};
        tbl[10] = '{0, 32'h0,   32'h0,        0, 0, 0, 1, 32'h0,   32'h0,        3'd0};

        qif.valid_i = 0; qif.inst_i = 0; qif.instAddr_i = 0;
        qif.jumpFlag_i = 0; qif.ready_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid_o", 64'(qif.valid_o), 64'(0));
        chk("reset ready_o", 64'(qif.ready_o), 64'(1));
        chk("reset count_o", 64'(qif.count_o), 64'(0));
        chk("reset inst_o", 64'(qif.inst_o), 64'(0));
        chk("reset instAddr_o", 64'(qif.instAddr_o), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Single push, fill to full, blocked fifth push, drain in order.
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].v, tbl[i].inst, tbl[i].addr, tbl[i].j, tbl[i].r, ov, orr, oinst, oaddr, ocnt);
            chk($sformatf("tbl[%0d] valid_o", i), 64'(ov), 64'(tbl[i].ev));
            chk($sformatf("tbl[%0d] ready_o", i), 64'(orr), 64'(tbl[i].er));
            chk($sformatf("tbl[%0d] inst_o", i), 64'(oinst), 64'(tbl[i].einst));
            chk($sformatf("tbl[%0d] instAddr_o", i), 64'(oaddr), 64'(tbl[i].eaddr));
            chk($sformatf("tbl[%0d] count_o", i), 64'(ocnt), 64'(tbl[i].ecnt));
        end

        // Streaming across pointer wrap: occupancy stays at one.
        for (int k = 0; k < 10; k++) begin
            cyc(1, 32'h200 + 32'(k), 32'h80000100 + 32'(4 * k), 0, 1, ov, orr, oinst, oaddr, ocnt);
            if (k > 0) begin
                chk("stream count_o", 64'(ocnt), 64'(1));
                chk("stream instAddr_o", 64'(oaddr), 64'(32'h80000100 + 32'(4 * (k - 1))));
            end
        end
        cyc(0, 0, 0, 0, 1, ov, orr, oinst, oaddr, ocnt);
        chk("stream last addr", 64'(oaddr), 64'(32'h80000124));

        // Flush at count 3 with a same-cycle push.
        for (int k = 0; k < 3; k++)
            cyc(1, 32'h300 + 32'(k), 32'h80000200 + 32'(4 * k), 0, 0, ov, orr, oinst, oaddr, ocnt);
        cyc(1, 32'h3FF, 32'h80000300, 1, 1, ov, orr, oinst, oaddr, ocnt);
        chk("flush valid_o", 64'(ov), 64'(0));
        chk("flush ready_o", 64'(orr), 64'(1));
        cyc(1, 32'h400, 32'h80001000, 0, 0, ov, orr, oinst, oaddr, ocnt);
        chk("post-flush count_o", 64'(ocnt), 64'(0));
        chk("post-flush valid_o", 64'(ov), 64'(0));
        cyc(1, 32'h401, 32'h80001004, 0, 0, ov, orr, oinst, oaddr, ocnt);
        chk("post-flush head", 64'(oaddr), 64'(32'h80001000));
        chk("post-flush head valid", 64'(ov), 64'(1));
        cyc(0, 0, 0, 0, 0, ov, orr, oinst, oaddr, ocnt);
        chk("pre-reset count_o", 64'(ocnt), 64'(2));

        // Asynchronous reset mid-operation.
        #1;
        reset_n = 1'b0;
        #1;
        chk("async reset count_o", 64'(qif.count_o), 64'(0));
        chk("async reset valid_o", 64'(qif.valid_o), 64'(0));
        chk("async reset ready_o", 64'(qif.ready_o), 64'(1));
        mq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1, 32'hAA, 32'h80002000, 0, 0, ov, orr, oinst, oaddr, ocnt);
        cyc(0, 0, 0, 0, 1, ov, orr, oinst, oaddr, ocnt);
        chk("after reset head", 64'(oaddr), 64'(32'h80002000));
        cyc(0, 0, 0, 0, 0, ov, orr, oinst, oaddr, ocnt);
        chk("after reset drained", 64'(ocnt), 64'(0));

        // Random traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 9) < 7), $urandom(), $urandom(),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 5),
                ov, orr, oinst, oaddr, ocnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
